// File: rtl/frame_byte_serialiser.sv
// frame_byte_serialiser
// Pops 128-bit trace frames from the frame buffer and streams them out as
// bytes: a sync byte followed by the 16 frame bytes, least-significant first.
// Stats packets carry port width, LEDs and frame counters. They are sent when
// requested, or after every STATS_INTERVAL frames. They are only inserted
// between packets. The byte sink uses a valid/accept handshake, and a byte
// moves when DataReady and DataNext are both high at a rising clock edge.
module frame_byte_serialiser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  STATS_BYTE     = 8'hA6,
  parameter logic [15:0] STATS_INTERVAL = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] Frame,
  input  logic         FrameReady,
  output logic         FrameNext,
  input  logic [1:0]   Width,
  input  logic [7:0]   Leds,
  input  logic [31:0]  TotalFrames,
  input  logic [15:0]  LostFrames,
  input  logic         StatsReq,
  output logic [7:0]   DataVal,
  output logic         DataReady,
  input  logic         DataNext
);

  // Index of the last data byte of a frame packet (16 bytes after the sync byte)
  localparam logic [3:0]  FRAME_LAST_IDX = 4'd15;
  // Index of the last byte of a stats packet (9 bytes including the header)
  localparam logic [3:0]  STATS_LAST_IDX = 4'd8;
  // The frame counter sticks at this value rather than wrapping
  localparam logic [15:0] CNT_MAX        = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_STATS = 2'd3
  } state_t;

  // Registered state
  state_t         state_r;
  logic [127:0]   frame_r;
  logic [3:0]     idx_r;
  logic [15:0]    frame_cnt_r;
  logic           pending_r;
  logic [1:0]     width_r;
  logic [7:0]     leds_r;
  logic [31:0]    total_r;
  logic [15:0]    lost_r;
  logic [7:0]     data_val_r;
  logic           data_ready_r;
  logic           frame_next_r;

  // Next-state values from the combinational process
  state_t         state_s;
  logic [127:0]   frame_s;
  logic [3:0]     idx_s;
  logic [15:0]    frame_cnt_s;
  logic           pending_s;
  logic [1:0]     width_s;
  logic [7:0]     leds_s;
  logic [31:0]    total_s;
  logic [15:0]    lost_s;
  logic [7:0]     data_val_s;
  logic           data_ready_s;
  logic           frame_next_s;

  // Helper terms
  logic           xfer_s;
  logic           stats_due_s;

  // Selects byte i of a latched frame, byte 0 being bits [7:0]
  function automatic logic [7:0] frame_byte(input logic [127:0] f, input logic [3:0] i);
    frame_byte = f[{i, 3'b000} +: 8];
  endfunction

  // Selects byte i of a stats packet built from the snapshot registers
  function automatic logic [7:0] stats_byte(
    input logic [3:0]  i,
    input logic [1:0]  w,
    input logic [7:0]  l,
    input logic [31:0] t,
    input logic [15:0] lo
  );
    case (i)
      4'd0:    stats_byte = STATS_BYTE;
      4'd1:    stats_byte = {6'b000000, w};
      4'd2:    stats_byte = l;
      4'd3:    stats_byte = t[7:0];
      4'd4:    stats_byte = t[15:8];
      4'd5:    stats_byte = t[23:16];
      4'd6:    stats_byte = t[31:24];
      4'd7:    stats_byte = lo[7:0];
      4'd8:    stats_byte = lo[15:8];
      default: stats_byte = 8'h00;
    endcase
  endfunction

  assign xfer_s      = data_ready_r & DataNext;
  assign stats_due_s = pending_r |
                       ((STATS_INTERVAL != 16'd0) && (frame_cnt_r == STATS_INTERVAL));

  // Next-state and output decode. Every register holds its value unless a branch changes it.
  always_comb begin
    state_s      = state_r;
    frame_s      = frame_r;
    idx_s        = idx_r;
    frame_cnt_s  = frame_cnt_r;
    pending_s    = pending_r | StatsReq;
    width_s      = width_r;
    leds_s       = leds_r;
    total_s      = total_r;
    lost_s       = lost_r;
    data_val_s   = data_val_r;
    data_ready_s = data_ready_r;
    frame_next_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        data_ready_s = 1'b0;
        if (stats_due_s) begin
          // Freeze the status inputs so the whole packet shows one consistent snapshot
          width_s      = Width;
          leds_s       = Leds;
          total_s      = TotalFrames;
          lost_s       = LostFrames;
          frame_cnt_s  = 16'd0;
          pending_s    = 1'b0;
          idx_s        = 4'd0;
          data_val_s   = STATS_BYTE;
          data_ready_s = 1'b1;
          state_s      = ST_STATS;
        end else if (FrameReady) begin
          // Latch the head frame and pop it from the buffer in the same step
          frame_s      = Frame;
          frame_next_s = 1'b1;
          data_val_s   = SYNC_BYTE;
          data_ready_s = 1'b1;
          state_s      = ST_HDR;
        end else begin
          state_s      = ST_IDLE;
        end
      end

      ST_HDR: begin
        if (xfer_s) begin
          idx_s      = 4'd0;
          data_val_s = frame_byte(frame_r, 4'd0);
          state_s    = ST_DATA;
        end else begin
          state_s    = ST_HDR;
        end
      end

      ST_DATA: begin
        if (xfer_s) begin
          if (idx_r != FRAME_LAST_IDX) begin
            idx_s      = idx_r + 4'd1;
            data_val_s = frame_byte(frame_r, idx_r + 4'd1);
          end else begin
            // Last frame byte has been accepted. The next cycle in IDLE is the bubble between packets.
            data_ready_s = 1'b0;
            frame_cnt_s  = (frame_cnt_r == CNT_MAX) ? CNT_MAX : frame_cnt_r + 16'd1;
            state_s      = ST_IDLE;
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_STATS: begin
        if (xfer_s) begin
          if (idx_r != STATS_LAST_IDX) begin
            idx_s      = idx_r + 4'd1;
            data_val_s = stats_byte(idx_r + 4'd1, width_r, leds_r, total_r, lost_r);
          end else begin
            data_ready_s = 1'b0;
            state_s      = ST_IDLE;
          end
        end else begin
          state_s = ST_STATS;
        end
      end

      default: begin
        data_ready_s = 1'b0;
        state_s      = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and active-low, and it abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      frame_r      <= 128'h0;
      idx_r        <= 4'd0;
      frame_cnt_r  <= 16'd0;
      pending_r    <= 1'b0;
      width_r      <= 2'd0;
      leds_r       <= 8'h00;
      total_r      <= 32'h0;
      lost_r       <= 16'h0;
      data_val_r   <= 8'h00;
      data_ready_r <= 1'b0;
      frame_next_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_r      <= frame_s;
      idx_r        <= idx_s;
      frame_cnt_r  <= frame_cnt_s;
      pending_r    <= pending_s;
      width_r      <= width_s;
      leds_r       <= leds_s;
      total_r      <= total_s;
      lost_r       <= lost_s;
      data_val_r   <= data_val_s;
      data_ready_r <= data_ready_s;
      frame_next_r <= frame_next_s;
    end
  end

  assign FrameNext = frame_next_r;
  assign DataVal   = data_val_r;
  assign DataReady = data_ready_r;

endmodule
